vdp_scanout: RTL
================

Name: vdp_scanout

Overview:
- Display-side consumer of the tile/sprite line buffer. Generates raster timing and pulses `start`/`line` to the line renderer one scanline ahead of display.
- Reads the finished line back through the line buffer's second port and maps each 5-bit pixel index through a 32-entry colour RAM (CRAM) to RGB.
- Adds border, left-column masking, display enable, vblank interrupt and line interrupt.

Parameters:
H_TOTAL, 342, clocks per scanline (one clock = one pixel)
H_ACTIVE, 256, visible pixels per line, hcnt 0..H_ACTIVE-1
HS_START, 280, first hcnt with hsync asserted
HS_LEN, 26, hsync width in clocks
V_TOTAL, 262, lines per frame
V_START, 24, first vcnt of active display
V_ACTIVE, 192, active lines
VS_START, 240, first vcnt with vsync asserted
VS_LEN, 3, vsync width in lines

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
disp_en  in  1  0: whole active area shows border colour
mask_col0  in  1  1: pixels 0..7 of each line show border colour
border_idx  in  4  border colour, CRAM entry {1'b1, border_idx}
line_irq_reload  in  8  line-interrupt counter reload value
cram_wr  in  1  CRAM write strobe
cram_addr  in  5  CRAM write address
cram_wrdata  in  6  CRAM data, {B[1:0], G[1:0], R[1:0]}
start  out  1  one-clock render-start pulse to line renderer
line  out  8  line number to render, valid while start=1
linebuf_rdidx  out  8  line buffer read index
linebuf_data  in  5  line buffer pixel, valid 1 clock after linebuf_rdidx
r, g, b  out  4 each  pixel colour, 2-bit CRAM field replicated ({c,c})
hsync, vsync, de  out  1 each  sync and data enable, active-high, latency-aligned with rgb
irq_vblank  out  1  one-clock pulse
irq_line  out  1  one-clock pulse

Behaviour:
- **Reset:** all outputs 0; hcnt=vcnt=0; line counter = 0; all 32 CRAM entries = 0. Reset mid-frame restarts the raster at hcnt=vcnt=0 on the next clock, and no pulse is emitted in the reset cycle.
- **Counters:**
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
- **Render request:**
  - Condition: hcnt==H_ACTIVE and rl = vcnt+1-V_START lies in 0..V_ACTIVE-1.
  - Action: start=1 for that one clock and line=rl[7:0].
  - Consequence: the line displayed on vcnt is the line rendered during the previous scanline. The renderer owns the line-select toggle.
- **Read pipeline** (latency 2):
  - S0: linebuf_rdidx = hcnt[7:0], registered alongside hcnt.
  - S1:
    - inside = (hcnt<H_ACTIVE) and vcnt in [V_START, V_START+V_ACTIVE).
    - idx = linebuf_data if inside and disp_en and not (mask_col0 and hcnt<8).
    - Otherwise idx = {1'b1, border_idx}.
  - S2: r/g/b registered from CRAM[idx].
  - hsync/vsync/de are computed at S0 and delayed 2 clocks. de = S0 condition (hcnt<H_ACTIVE and vcnt active), independent of disp_en.
- **Syncs:** hsync = hcnt in [HS_START, HS_START+HS_LEN); vsync = vcnt in [VS_START, VS_START+VS_LEN).
- **CRAM:**
  - A write takes effect at the clock edge.
  - A same-cycle S2 lookup of the written entry returns the old value; the new value is visible from the next pixel onward.
  - There is no read port to the CPU.
- **irq_vblank:** pulse at hcnt==0, vcnt==V_START+V_ACTIVE.
- **Line interrupt:**
  - Evaluated at hcnt==H_ACTIVE on every line.
  - On an active line:
    - If counter==0, counter <= line_irq_reload and irq_line=1.
    - Otherwise counter decrements by 1.
  - On a non-active line, counter <= line_irq_reload.
  - line_irq_reload is sampled only at reload.
- All arithmetic is unsigned. rl is computed 9-bit wide so vcnt<V_START-1 gives a negative (out-of-range) value and no pulse.

Test Plan:
1. Reset, run one frame → exactly 192 start pulses; first at vcnt=23 with line=0; last at vcnt=214 with line=191; each at hcnt=256.
2. Write CRAM[3]=6'b11_10_01 and set linebuf_data=3 for all indices, disp_en=1 → on active pixels r=4'h5, g=4'hA, b=4'hF, appearing 2 clocks after linebuf_rdidx, with de=1.
3. mask_col0=1, border_idx=2, CRAM[18]=6'h3F → pixels 0..7 of each active line show F/F/F and pixel 8 shows the linebuf colour. disp_en=0 → all 256 pixels show border and de still 1.
4. Sync timing → hsync high for hcnt 280..305 (delayed 2); vsync high for vcnt 240..242; irq_vblank single pulse at vcnt=216, hcnt=0.
5. line_irq_reload=3 → irq_line on active lines 3, 7, 11, … (every 4th line); reload 0 → pulse every active line; no pulses outside active lines.
6. Assert reset at vcnt=100 for 1 clock → all outputs 0 the next clock; raster restarts at 0,0 and the next start pulse is at vcnt=23.

Source files
------------

// File: rtl/vdp_scanout.sv
// rtl/vdp_scanout.sv - raster timing, render requests, line buffer readback and CRAM colour lookup
`timescale 1ns/1ps

module vdp_scanout #(
    parameter int H_TOTAL  = 342,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 280,
    parameter int HS_LEN   = 26,
    parameter int V_TOTAL  = 262,
    parameter int V_START  = 24,
    parameter int V_ACTIVE = 192,
    parameter int VS_START = 240,
    parameter int VS_LEN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disp_en,
    input  logic       mask_col0,
    input  logic [3:0] border_idx,
    input  logic [7:0] line_irq_reload,
    input  logic       cram_wr,
    input  logic [4:0] cram_addr,
    input  logic [5:0] cram_wrdata,
    output logic       start,
    output logic [7:0] line,
    output logic [7:0] linebuf_rdidx,
    input  logic [4:0] linebuf_data,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       irq_vblank,
    output logic       irq_line
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] HS_S   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_START + HS_LEN);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_S    = 9'(V_START);
    localparam logic [8:0] V_E    = 9'(V_START + V_ACTIVE);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] VS_S   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_START + VS_LEN);

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic [7:0] lic_q, lic_d;
    logic [7:0] rdidx_q;
    logic       s1_inside_q, s1_col0_q, s1_hs_q, s1_vs_q;
    logic [5:0] col_q;
    logic       hs_q, vs_q, de_q;
    logic [5:0] cram_q [32];

    logic [8:0] rl;
    logic       v_act, h_act, render_hit, irq_hit;
    logic [4:0] pix_idx;

    always_comb begin
        hcnt_d = hcnt_q + 9'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 9'd1;
        end
    end

    // Wraps negative above the top border, so the single compare rejects both ends.
    assign rl         = vcnt_q + 9'd1 - V_S;
    assign v_act      = (vcnt_q >= V_S) && (vcnt_q < V_E);
    assign h_act      = hcnt_q < H_ACT;
    assign render_hit = (hcnt_q == H_ACT) && (rl < V_ACT);

    always_comb begin
        lic_d   = lic_q;
        irq_hit = 1'b0;
        if (hcnt_q == H_ACT) begin
            if (!v_act) begin
                lic_d = line_irq_reload;
            end else if (lic_q == 8'd0) begin
                lic_d   = line_irq_reload;
                irq_hit = 1'b1;
            end else begin
                lic_d = lic_q - 8'd1;
            end
        end
    end

    always_comb begin
        pix_idx = {1'b1, border_idx};
        if (s1_inside_q && disp_en && !(mask_col0 && s1_col0_q)) begin
            pix_idx = linebuf_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            lic_q       <= '0;
            rdidx_q     <= '0;
            s1_inside_q <= 1'b0;
            s1_col0_q   <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            col_q       <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            lic_q       <= lic_d;
            rdidx_q     <= hcnt_d[7:0];
            s1_inside_q <= h_act && v_act;
            s1_col0_q   <= hcnt_q < 9'd8;
            s1_hs_q     <= (hcnt_q >= HS_S) && (hcnt_q < HS_E);
            s1_vs_q     <= (vcnt_q >= VS_S) && (vcnt_q < VS_E);
            col_q       <= cram_q[pix_idx];
            hs_q        <= s1_hs_q;
            vs_q        <= s1_vs_q;
            de_q        <= s1_inside_q;
        end
    end

    // Lookup above samples the pre-write entry when both hit the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cram_q[i] <= '0;
            end
        end else if (cram_wr) begin
            cram_q[cram_addr] <= cram_wrdata;
        end
    end

    assign start         = render_hit && !reset;
    assign line          = start ? rl[7:0] : 8'd0;
    assign irq_line      = irq_hit && !reset;
    assign irq_vblank    = (hcnt_q == 9'd0) && (vcnt_q == V_E) && !reset;
    assign linebuf_rdidx = rdidx_q;
    assign r             = {col_q[1:0], col_q[1:0]};
    assign g             = {col_q[3:2], col_q[3:2]};
    assign b             = {col_q[5:4], col_q[5:4]};
    assign hsync         = hs_q;
    assign vsync         = vs_q;
    assign de            = de_q;

endmodule
